// File: rtl/dmem_port_sequencer.sv
// Serialises up to two per-bundle memory ops (slot 0 then slot 1) onto one dataMem port, stalling until done.
// Optional miss watchdog enabled by defining DMEM_SEQ_TIMEOUT_EN.
module dmem_port_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int WDATA_W        = 32,
  parameter int RDATA_W        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req0_we,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WDATA_W-1:0] req0_wdata,
  input  logic               req1_valid,
  input  logic               req1_we,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WDATA_W-1:0] req1_wdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic               mem_hit,
  input  logic [RDATA_W-1:0] mem_rdata,
  output logic               stall,
  output logic               rsp0_valid,
  output logic [RDATA_W-1:0] rsp0_rdata,
  output logic               rsp1_valid,
  output logic [RDATA_W-1:0] rsp1_rdata,
  output logic [15:0]        miss_cnt,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t               state;
  logic                 v0_q, we0_q, v1_q, we1_q;
  logic [ADDR_W-1:0]    a0_q, a1_q;
  logic [WDATA_W-1:0]   d0_q, d1_q;
  logic [RDATA_W-1:0]   rd0_q, rd1_q;
  logic [15:0]          miss_q;
  logic                 acc, sel1, miss, abandon, op_done;
  logic [RDATA_W-1:0]   cap;

  assign acc     = (state == ACC0) || (state == ACC1);
  assign sel1    = (state == ACC1);
  assign miss    = acc && !mem_hit;
  assign op_done = acc && (mem_hit || abandon);
  // An abandoned op returns zero rather than whatever sits on the bus.
  assign cap     = mem_hit ? mem_rdata : '0;

`ifdef DMEM_SEQ_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        err_q;

  assign abandon = miss && (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (miss && !abandon) ? wd_q + 16'd1 : 16'd0;
      if (abandon) err_q <= 1'b1;
    end
  end
`else
  assign abandon = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      v0_q   <= 1'b0;
      we0_q  <= 1'b0;
      a0_q   <= '0;
      d0_q   <= '0;
      v1_q   <= 1'b0;
      we1_q  <= 1'b0;
      a1_q   <= '0;
      d1_q   <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      miss_q <= '0;
    end else begin
      if (miss && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      case (state)
        IDLE: begin
          v0_q  <= req0_valid;
          we0_q <= req0_we;
          a0_q  <= req0_addr;
          d0_q  <= req0_wdata;
          v1_q  <= req1_valid;
          we1_q <= req1_we;
          a1_q  <= req1_addr;
          d1_q  <= req1_wdata;
          if (req0_valid)      state <= ACC0;
          else if (req1_valid) state <= ACC1;
        end
        ACC0: if (op_done) begin
          if (!we0_q) rd0_q <= cap;
          state <= v1_q ? ACC1 : DONE;
        end
        ACC1: if (op_done) begin
          if (!we1_q) rd1_q <= cap;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port side is driven only from latched copies, so requester changes mid-access are invisible.
  assign mem_en     = acc;
  assign mem_we     = acc && (sel1 ? we1_q : we0_q);
  assign mem_addr   = acc ? (sel1 ? a1_q : a0_q) : '0;
  assign mem_wdata  = acc ? (sel1 ? d1_q : d0_q) : '0;
  assign stall      = (state == IDLE) ? (req0_valid || req1_valid) : acc;
  assign rsp0_valid = (state == DONE) && v0_q && !we0_q;
  assign rsp1_valid = (state == DONE) && v1_q && !we1_q;
  assign rsp0_rdata = rd0_q;
  assign rsp1_rdata = rd1_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_dmem_port_sequencer.sv
// Randomised and directed bench for dmem_port_sequencer with a bundle-level reference model.
module tb_dmem_port_sequencer;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        mem_en, mem_we, mem_hit, stall;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_rdata, rsp0_rdata, rsp1_rdata;
  logic        rsp0_valid, rsp1_valid, err;
  logic [15:0] miss_cnt;

  dmem_port_sequencer #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_hit(mem_hit), .mem_rdata(mem_rdata), .stall(stall),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .miss_cnt(miss_cnt), .err(err));

  always #5 clk = ~clk;

  logic [7:0] dmem    [0:255];
  logic [7:0] ref_mem [0:255];
  int   checks = 0, errors = 0, exp_miss = 0;
  bit   exp_err = 1'b0;
  logic [7:0] last_r0 = 8'h00, last_r1 = 8'h00;

  task automatic clear_reqs();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the bundle's final (non-stall) cycle.
  task automatic run_bundle(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0, input int m0,
                            input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1, input int m1);
    logic [31:0] q_addr[$];
    bit          q_we[$];
    logic [31:0] q_wd[$];
    int          q_m[$];
    bit          q_ab[$];
    bit   e_rv0, e_rv1, fin, ab;
    logic [7:0] e_r0, e_r1;
    int   exp_stall, stalls, em;
    e_r0 = last_r0; e_r1 = last_r1; e_rv0 = v0 && !w0; e_rv1 = v1 && !w1;
    exp_stall = (v0 || v1) ? 1 : 0;
    for (int s = 0; s < 2; s++) begin
      bit v, w; logic [31:0] a, d; int m;
      v = s ? v1 : v0; w = s ? w1 : w0; a = s ? a1 : a0; d = s ? d1 : d0; m = s ? m1 : m0;
      if (v) begin
        ab = 1'b0; em = m;
`ifdef DMEM_SEQ_TIMEOUT_EN
        if (m >= TO) begin ab = 1'b1; em = TO; end
`endif
        exp_stall += 1 + em;
        if (!w) begin
          if (s == 0) e_r0 = ab ? 8'h00 : ref_mem[a[7:0]];
          else        e_r1 = ab ? 8'h00 : ref_mem[a[7:0]];
        end else if (!ab) ref_mem[a[7:0]] = d[7:0];
        q_addr.push_back(a); q_we.push_back(w); q_wd.push_back(d); q_m.push_back(em); q_ab.push_back(ab);
      end
    end
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    stalls = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      #1;
      checks++;
      if (!mem_en && mem_we !== 1'b0) begin errors++; $display("FAIL we_without_en got %b exp 0", mem_we); end
      if (stall === 1'b1) begin
        stalls++;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
          errors++; $display("FAIL rsp_during_stall got %b%b exp 00", rsp0_valid, rsp1_valid);
        end
        mem_hit = 1'b0;
        if (mem_en === 1'b1) begin
          checks++;
          if (q_addr.size() == 0) begin
            errors++; $display("FAIL extra_access got addr %h exp none", mem_addr); mem_hit = 1'b1;
          end else begin
            if (mem_addr !== q_addr[0] || mem_we !== q_we[0] || (q_we[0] && mem_wdata !== q_wd[0])) begin
              errors++;
              $display("FAIL port_order got a=%h we=%b wd=%h exp a=%h we=%b wd=%h",
                       mem_addr, mem_we, mem_wdata, q_addr[0], q_we[0], q_wd[0]);
            end
            if (q_m[0] > 0) begin
              q_m[0]--; exp_miss++;
              if (q_m[0] == 0 && q_ab[0]) begin
                exp_err = 1'b1;
                void'(q_addr.pop_front()); void'(q_we.pop_front()); void'(q_wd.pop_front());
                void'(q_m.pop_front()); void'(q_ab.pop_front());
              end
            end else begin
              mem_hit = 1'b1;
              if (mem_we) dmem[mem_addr[7:0]] = mem_wdata[7:0];
              else mem_rdata = dmem[mem_addr[7:0]];
              void'(q_addr.pop_front()); void'(q_we.pop_front()); void'(q_wd.pop_front());
              void'(q_m.pop_front()); void'(q_ab.pop_front());
            end
          end
        end
      end else begin
        fin = 1'b1; mem_hit = 1'b0;
        checks += 6;
        if (stalls != exp_stall) begin errors++; $display("FAIL stall_cycles got %0d exp %0d", stalls, exp_stall); end
        if (q_addr.size() != 0 || mem_en !== 1'b0) begin
          errors++; $display("FAIL ops_outstanding got %0d en=%b exp 0 en=0", q_addr.size(), mem_en);
        end
        if (rsp0_valid !== e_rv0 || rsp1_valid !== e_rv1) begin
          errors++; $display("FAIL rsp_valid got %b%b exp %b%b", rsp0_valid, rsp1_valid, e_rv0, e_rv1);
        end
        if (rsp0_rdata !== e_r0 || rsp1_rdata !== e_r1) begin
          errors++; $display("FAIL rsp_rdata got %h %h exp %h %h", rsp0_rdata, rsp1_rdata, e_r0, e_r1);
        end
        if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL miss_cnt got %0d exp %0d", miss_cnt, exp_miss); end
        if (err !== exp_err) begin errors++; $display("FAIL err got %b exp %b", err, exp_err); end
      end
      @(posedge clk); #1;
    end
    if (!fin) begin errors++; checks++; $display("FAIL bundle_timeout got stall stuck exp done"); end
    last_r0 = e_r0; last_r1 = e_r1;
    clear_reqs();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_reqs(); mem_hit = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_en, mem_we, stall, rsp0_valid, rsp1_valid, err} !== 6'b0 || miss_cnt !== 16'h0 ||
        rsp0_rdata !== 8'h00 || rsp1_rdata !== 8'h00 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got en=%b we=%b st=%b rv=%b%b err=%b mc=%0d exp all 0",
               mem_en, mem_we, stall, rsp0_valid, rsp1_valid, err, miss_cnt);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dmem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    dmem[8'h20] = 8'h11; ref_mem[8'h20] = 8'h11;
    dmem[8'h24] = 8'h22; ref_mem[8'h24] = 8'h22;
    run_bundle(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    run_bundle(1, 0, 32'h20, 0, 0, 1, 0, 32'h24, 0, 0);
    run_bundle(1, 1, 32'h40, 32'h5C, 0, 1, 0, 32'h40, 0, 0);
    run_bundle(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 3);
    run_bundle(1, 1, 32'h44, 32'h77, 1, 1, 1, 32'h44, 32'h99, 0);
    run_bundle(0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 0);
    run_bundle(0, 0, 32'h44, 0, 0, 0, 0, 32'h44, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      bit v0, w0, v1, w1;
      logic [31:0] a0, a1, d0, d1;
      v0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 32'($urandom_range(0, 7) * 4); a1 = 32'($urandom_range(0, 7) * 4);
      d0 = $urandom; d1 = $urandom;
      run_bundle(v0, w0, a0, d0, $urandom_range(0, 2), v1, w1, a1, d1, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] mc_before;
    req0_valid = 1; req0_we = 0; req0_addr = 32'h20;
    req1_valid = 1; req1_we = 0; req1_addr = 32'h24;
    #1; mem_hit = 1'b0;
    @(posedge clk); #1;
    mem_hit = 1'b0;
    @(posedge clk); #1;
    mem_hit = 1'b1; mem_rdata = dmem[8'h20];
    @(posedge clk); #1;
    checks++;
    if (mem_addr !== 32'h24 || mem_en !== 1'b1) begin
      errors++; $display("FAIL reach_acc1 got en=%b a=%h exp en=1 a=00000024", mem_en, mem_addr);
    end
    mc_before = miss_cnt;
    checks++;
    if (mc_before == 16'h0) begin errors++; $display("FAIL pre_reset_miss got %0d exp nonzero", mc_before); end
    mem_hit = 1'b0; reset = 1'b1; clear_reqs();
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (mem_en !== 1'b0 || stall !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || miss_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_acc got en=%b st=%b rv=%b%b mc=%0d exp 0 0 00 0",
               mem_en, stall, rsp0_valid, rsp1_valid, miss_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_pulse got rv=%b%b en=%b exp 00 0", rsp0_valid, rsp1_valid, mem_en);
    end
    exp_miss = 0; exp_err = 1'b0; last_r0 = 8'h00; last_r1 = 8'h00;
    run_bundle(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef DMEM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_bundle(1, 0, 32'h10, 0, 10, 0, 0, 0, 0, 0);
    run_bundle(1, 0, 32'h24, 0, 0, 1, 1, 32'h28, 32'h3C, 9);
    run_bundle(0, 0, 0, 0, 0, 1, 0, 32'h28, 0, 1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom); ref_mem[i] = dmem[i];
    end
    test_reset();
    test_directed();
    test_back_to_back();
`ifdef DMEM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
